// File: rtl/lm07_spi_responder.sv
// LM07-style SPI read port: frames a 13-bit temperature code as {TEMP, 3'b111}
// and shifts it out MSB-first; CS and SCK are oversampled in the SYSCLK domain.
//
// state | meaning
// IDLE  | waiting for CS to fall
// LOAD  | one cycle: snapshot hold register into shift register
// SHIFT | shifting on each synchronized SCK fall
// DONE  | full word sent; further SCK falls shift out zeros
module lm07_spi_responder #(
    parameter int                DATA_W     = 13,
    parameter int                PAD_BITS   = 3,
    parameter int                WORD_W     = DATA_W + PAD_BITS,
    parameter int                SYNC_STG   = 2,
    parameter logic [DATA_W-1:0] RESET_TEMP = '0
) (
    input  logic              SYSCLK,
    input  logic              RSTN,
    input  logic              CS,
    input  logic              SCK,
    input  logic [DATA_W-1:0] TEMP,
    input  logic              TEMP_VLD,
    output logic              SIO,
    output logic              SIO_OE,
    output logic              BUSY,
    output logic              RD_DONE
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t              state;
    logic [SYNC_STG-1:0] cs_sync;
    logic [SYNC_STG-1:0] sck_sync;
    logic                cs_d;
    logic                sck_d;
    logic                cs_s;
    logic                sck_s;
    logic                cs_fall;
    logic                cs_rise;
    logic                sck_fall;
    logic [DATA_W-1:0]   hold;
    logic [WORD_W-1:0]   shift;
    logic [CNT_W-1:0]    bitcnt;

    assign cs_s     = cs_sync[SYNC_STG-1];
    assign sck_s    = sck_sync[SYNC_STG-1];
    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_fall = sck_d & ~sck_s;
    assign SIO_OE   = ~cs_s;

    // Synchronizers reset to the idle bus levels so no edge is seen at release.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            cs_sync  <= '1;
            sck_sync <= '0;
            cs_d     <= 1'b1;
            sck_d    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STG-2:0], CS};
            sck_sync <= {sck_sync[SYNC_STG-2:0], SCK};
            cs_d     <= cs_s;
            sck_d    <= sck_s;
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            hold <= RESET_TEMP;
        end else if (TEMP_VLD) begin
            hold <= TEMP;
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= IDLE;
            shift   <= '0;
            bitcnt  <= '0;
            BUSY    <= 1'b0;
            RD_DONE <= 1'b0;
            SIO     <= 1'b0;
        end else begin
            RD_DONE <= 1'b0;
            SIO     <= ~cs_s & shift[WORD_W-1];
            // A CS rise aborts from any active state and beats a coincident SCK fall.
            if (state != IDLE && cs_rise) begin
                state  <= IDLE;
                shift  <= '0;
                bitcnt <= '0;
                BUSY   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state <= LOAD;
                            BUSY  <= 1'b1;
                        end
                    end
                    LOAD: begin
                        shift  <= {hold, {PAD_BITS{1'b1}}};
                        bitcnt <= '0;
                        state  <= SHIFT;
                    end
                    SHIFT: begin
                        if (sck_fall) begin
                            shift  <= shift << 1;
                            bitcnt <= bitcnt + 1'b1;
                            if (bitcnt == CNT_W'(WORD_W - 1)) begin
                                state   <= DONE;
                                RD_DONE <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (sck_fall) begin
                            shift <= shift << 1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lm07_spi_responder.sv
// Directed bench for lm07_spi_responder: table of read transactions plus
// hand-written reset, mid-read update and LOAD-cycle collision sequences.
module tb_lm07_spi_responder;

    logic        sysclk = 1'b0;
    logic        rstn   = 1'b0;
    logic        cs     = 1'b1;
    logic        sck    = 1'b0;
    logic [12:0] temp   = '0;
    logic        temp_vld = 1'b0;
    logic        sio;
    logic        sio_oe;
    logic        busy;
    logic        rd_done;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    lm07_spi_responder dut (
        .SYSCLK   (sysclk),
        .RSTN     (rstn),
        .CS       (cs),
        .SCK      (sck),
        .TEMP     (temp),
        .TEMP_VLD (temp_vld),
        .SIO      (sio),
        .SIO_OE   (sio_oe),
        .BUSY     (busy),
        .RD_DONE  (rd_done)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) if (rd_done === 1'b1) done_seen = done_seen + 1;

    typedef struct {
        logic        ld;
        logic [12:0] val;
        int          n;
        logic [31:0] exp_bits;
        int          exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [12:0] v);
        @(negedge sysclk);
        temp     = v;
        temp_vld = 1'b1;
        @(negedge sysclk);
        temp_vld = 1'b0;
    endtask

    // strobe_at = -1 pulses TEMP_VLD in the LOAD cycle; >=0 pulses it during that SCK high phase
    task automatic spi_read(input string name, input int n, input int strobe_at,
                            input logic [12:0] sval, input logic [31:0] exp_bits,
                            input int exp_done);
        logic [31:0] bits;
        int          d0;
        bits = '0;
        d0   = done_seen;
        @(negedge sysclk);
        cs = 1'b0;
        if (strobe_at == -1) begin
            repeat (2) @(negedge sysclk);
            check({name, "_busy_pre_load"}, {31'd0, busy}, 32'd0);
            @(negedge sysclk);
            check({name, "_busy_in_load"}, {31'd0, busy}, 32'd1);
            temp     = sval;
            temp_vld = 1'b1;
            @(negedge sysclk);
            temp_vld = 1'b0;
            repeat (4) @(negedge sysclk);
        end else begin
            repeat (8) @(negedge sysclk);
        end
        check({name, "_sio_oe"}, {31'd0, sio_oe}, 32'd1);
        for (int i = 0; i < n; i++) begin
            bits = {bits[30:0], sio};
            sck  = 1'b1;
            if (i == strobe_at) begin
                @(negedge sysclk);
                temp     = sval;
                temp_vld = 1'b1;
                @(negedge sysclk);
                temp_vld = 1'b0;
                repeat (2) @(negedge sysclk);
            end else begin
                repeat (4) @(negedge sysclk);
            end
            sck = 1'b0;
            repeat (4) @(negedge sysclk);
        end
        repeat (4) @(negedge sysclk);
        check({name, "_busy_open"}, {31'd0, busy}, 32'd1);
        cs = 1'b1;
        repeat (6) @(negedge sysclk);
        check({name, "_bits"}, bits, exp_bits);
        check({name, "_rd_done"}, done_seen - d0, exp_done);
        check({name, "_idle_outs"}, {29'd0, sio, sio_oe, busy}, 32'd0);
        repeat (4) @(negedge sysclk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 13'h0000, 16, 32'h0000_0007, 1};
        vecs[1] = '{1'b1, 13'h0880, 16, 32'h0000_4407, 1};
        vecs[2] = '{1'b0, 13'h0000,  7, 32'h0000_0022, 0};
        vecs[3] = '{1'b0, 13'h0000, 16, 32'h0000_4407, 1};
        vecs[4] = '{1'b0, 13'h0000, 20, 32'h0004_4070, 1};
        vecs[5] = '{1'b1, 13'h1555, 16, 32'h0000_AAAF, 1};
        vecs[6] = '{1'b0, 13'h0000,  0, 32'h0000_0000, 0};
        vecs[7] = '{1'b1, 13'h1FFF, 16, 32'h0000_FFFF, 1};

        // reset held while CS toggles
        for (int i = 0; i < 6; i++) begin
            @(negedge sysclk);
            cs = ~cs;
            sck = ~sck;
            @(negedge sysclk);
            check("reset_outs", {28'd0, sio, sio_oe, busy, rd_done}, 32'd0);
        end
        @(negedge sysclk);
        cs  = 1'b1;
        sck = 1'b0;
        repeat (3) @(negedge sysclk);
        rstn = 1'b1;
        repeat (4) @(negedge sysclk);
        check("post_reset_outs", {28'd0, sio, sio_oe, busy, rd_done}, 32'd0);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].ld) strobe(vecs[v].val);
            spi_read($sformatf("vec%0d", v), vecs[v].n, -2, 13'h0, vecs[v].exp_bits, vecs[v].exp_done);
        end

        // update mid-read: current word frozen, next read picks up the new code
        strobe(13'h0880);
        spi_read("upd_cur", 16, 5, 13'h1FFF, 32'h0000_4407, 1);
        spi_read("upd_next", 16, -2, 13'h0, 32'h0000_FFFF, 1);

        // TEMP_VLD coincident with LOAD: old word goes out
        strobe(13'h0880);
        spi_read("coll_cur", 16, -1, 13'h1FFF, 32'h0000_4407, 1);
        spi_read("coll_next", 16, -2, 13'h0, 32'h0000_FFFF, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
